mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings, grant identifiers and bus constants for mem_port_arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2,
        ARB_RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [3:0]  SEL_ALL_BYTES = 4'b1111;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between IF and MEM requesters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; default is MEM-over-IF.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
    input  grant_e last_grant,
    output logic   grant_if,
    output logic   grant_mem
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_if  = if_req;
        grant_mem = mem_req;
        if (if_req && mem_req) begin
            // Contention: hand the bus to whoever did not have it last.
            grant_mem = (last_grant == GRANT_IF);
            grant_if  = (last_grant == GRANT_MEM);
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // MEM holds the older instruction, so it always wins.
    assign grant_mem = mem_req;
    assign grant_if  = if_req & ~mem_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-bus arbiter between instruction fetch and load/store; one transaction at a time.
// Build option: MEM_ARB_ROUND_ROBIN_EN (alternate grants under contention, see mem_arb_pick).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [3:0]        mem_sel_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic              mem_stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);

    arb_state_e        state_q, state_d;
    grant_e            owner_q, owner_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] ack_word;
    logic              grant_if, grant_mem;

    // owner_q doubles as the last-grant memory; the picker ignores it in fixed-priority builds.
    mem_arb_pick u_pick (
        .if_req     (if_req_i),
        .mem_req    (mem_req_i),
        .last_grant (owner_q),
        .grant_if   (grant_if),
        .grant_mem  (grant_mem)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        ack_word    = bus_we_q ? '0 : bus_rdata_i;

        case (state_q)
            ARB_IDLE: begin
                if (grant_mem) begin
                    state_d     = ARB_BUSY_MEM;
                    owner_d     = GRANT_MEM;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    bus_sel_d   = mem_sel_i;
                end else if (grant_if) begin
                    state_d     = ARB_BUSY_IF;
                    owner_d     = GRANT_IF;
                    bus_we_d    = WRITE_DISABLE;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                    bus_sel_d   = SEL_ALL_BYTES;
                end
            end
            ARB_BUSY_IF: begin
                if (bus_ack_i) begin
                    if_rdata_d = ack_word;
                    state_d    = ARB_RESP;
                end
            end
            ARB_BUSY_MEM: begin
                if (bus_ack_i) begin
                    mem_rdata_d = ack_word;
                    state_d     = ARB_RESP;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= GRANT_IF;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Request and done derive from state so an async reset clears them immediately.
    assign bus_req_o   = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_MEM);
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o   = bus_sel_q;

    assign if_done_o   = (state_q == ARB_RESP) && (owner_q == GRANT_IF);
    assign mem_done_o  = (state_q == ARB_RESP) && (owner_q == GRANT_MEM);
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_stall_o  = if_req_i & ~if_done_o;
    assign mem_stall_o = mem_req_i & ~mem_done_o;

endmodule
